// File: rtl/decodificador_quadratura.sv
// Quadrature decoder: synchronizes and glitch-filters encoder phases A/B and
// emits one-cycle acrescer/decrescer pulses plus a sticky illegal-transition flag.
module decodificador_quadratura #(
    parameter int unsigned FILTRO = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic canal_a,
    input  logic canal_b,
    input  logic habilitar,
    input  logic limpar_erro,
    output logic acrescer,
    output logic decrescer,
    output logic erro
);

    localparam int unsigned CNT_W      = $clog2(FILTRO + 1);
    localparam int unsigned ASSENTAR_W = $clog2(FILTRO + 2);
    localparam int unsigned N_CANAIS   = 2;

    localparam logic [CNT_W-1:0]      CNT_LIMITE   = CNT_W'(FILTRO - 1);
    localparam logic [ASSENTAR_W-1:0] ASSENTAR_FIM = ASSENTAR_W'(FILTRO + 1);

    typedef enum logic {
        INICIAL = 1'b0,
        ATIVO   = 1'b1
    } estado_t;

    estado_t               estado;
    logic [1:0]            sinc [N_CANAIS];
    logic [CNT_W-1:0]      cnt  [N_CANAIS];
    logic [N_CANAIS-1:0]   filt;
    logic [N_CANAIS-1:0]   prev;
    logic [ASSENTAR_W-1:0] assentar;

    logic [N_CANAIS-1:0] sinc_s;
    logic                passo_fwd;
    logic                passo_rev;
    logic                passo_ilegal;

    // Index 1 is phase A, index 0 is phase B, so filt reads as {A,B}.
    always_comb begin
        sinc_s = {sinc[1][1], sinc[0][1]};
    end

    // Classify the filtered step from prev to filt.
    always_comb begin
        passo_fwd    = 1'b0;
        passo_rev    = 1'b0;
        passo_ilegal = 1'b0;
        case ({prev, filt})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: passo_fwd    = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: passo_rev    = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: passo_ilegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= INICIAL;
            filt      <= '0;
            prev      <= '0;
            assentar  <= '0;
            acrescer  <= 1'b0;
            decrescer <= 1'b0;
            erro      <= 1'b0;
            for (int i = 0; i < int'(N_CANAIS); i++) begin
                sinc[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            sinc[1] <= {sinc[1][0], canal_a};
            sinc[0] <= {sinc[0][0], canal_b};

            case (estado)
                INICIAL: begin
                    // Track inputs directly so ATIVO starts with prev == filt.
                    filt      <= sinc_s;
                    prev      <= sinc_s;
                    acrescer  <= 1'b0;
                    decrescer <= 1'b0;
                    for (int i = 0; i < int'(N_CANAIS); i++) begin
                        cnt[i] <= '0;
                    end
                    if (assentar == ASSENTAR_FIM) begin
                        assentar <= '0;
                        estado   <= ATIVO;
                    end else begin
                        assentar <= assentar + ASSENTAR_W'(1);
                    end
                end

                ATIVO: begin
                    for (int i = 0; i < int'(N_CANAIS); i++) begin
                        if (sinc_s[i] == filt[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LIMITE) begin
                            filt[i] <= sinc_s[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    // prev keeps tracking while disabled, so re-enabling is not retroactive.
                    prev      <= filt;
                    acrescer  <= habilitar & passo_fwd;
                    decrescer <= habilitar & passo_rev;
                    if (habilitar && passo_ilegal) begin
                        erro <= 1'b1;
                    end else if (limpar_erro) begin
                        erro <= 1'b0;
                    end
                end

                default: begin
                    estado <= INICIAL;
                end
            endcase

            if (estado == INICIAL && limpar_erro) begin
                erro <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decodificador_quadratura.sv
// Scoreboard bench for decodificador_quadratura: stimulus queues expected pulses,
// a negedge monitor pops and compares them against acrescer/decrescer.
module tb_decodificador_quadratura;

    localparam int unsigned FILTRO = 4;
    localparam int          LAT    = int'(FILTRO) + 3;

    logic clk = 1'b0;
    logic rst;
    logic canal_a;
    logic canal_b;
    logic habilitar;
    logic limpar_erro;
    logic acrescer;
    logic decrescer;
    logic erro;

    decodificador_quadratura #(.FILTRO(FILTRO)) dut (
        .clk        (clk),
        .rst        (rst),
        .canal_a    (canal_a),
        .canal_b    (canal_b),
        .habilitar  (habilitar),
        .limpar_erro(limpar_erro),
        .acrescer   (acrescer),
        .decrescer  (decrescer),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit acr;
        int ciclo;
    } evento_t;

    evento_t sb[$];
    int ciclo    = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic verificar(input string nome, input logic atual, input logic esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %b expected %b at cycle %0d", nome, atual, esperado, ciclo);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        evento_t e;
        if (acrescer === 1'b1 && decrescer === 1'b1) begin
            n_checks++;
            $display("FAIL both_pulses: acrescer and decrescer high at cycle %0d", ciclo);
        end else if (acrescer === 1'b1 || decrescer === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: acrescer=%b decrescer=%b at cycle %0d, none expected",
                         acrescer, decrescer, ciclo);
            end else begin
                e = sb.pop_front();
                if (e.acr == acrescer && e.ciclo == ciclo) n_pass++;
                else $display("FAIL pulse: got acrescer=%b at cycle %0d, expected acrescer=%b at cycle %0d",
                              acrescer, ciclo, e.acr, e.ciclo);
            end
        end
    end

    // Drive {A,B}, optionally queue the expected pulse, then hold for espera cycles.
    task automatic passo(input logic a, input logic b, input bit tem_pulso, input bit acr,
                         input int espera);
        evento_t e;
        canal_a = a;
        canal_b = b;
        if (tem_pulso) begin
            e.acr   = acr;
            e.ciclo = ciclo + LAT;
            sb.push_back(e);
        end
        repeat (espera) @(negedge clk);
    endtask

    task automatic esperar(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drenar(input string nome);
        int limite;
        limite = 40;
        while (sb.size() > 0 && limite > 0) begin
            @(negedge clk);
            limite--;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: %0d expected pulses missing, required 0", nome, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; canal_a = 1'b0; canal_b = 1'b0; habilitar = 1'b1; limpar_erro = 1'b0;
        esperar(3);
        verificar("reset_acrescer", acrescer, 1'b0);
        verificar("reset_decrescer", decrescer, 1'b0);
        verificar("reset_erro", erro, 1'b0);
        verificar("reset_estado", dut.estado, 1'b0);
        rst = 1'b0;
        esperar(20);

        // Forward sequence
        passo(1'b0, 1'b1, 1, 1, 10);
        passo(1'b1, 1'b1, 1, 1, 10);
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("fwd_drain");
        verificar("fwd_erro", erro, 1'b0);

        // Reverse sequence
        passo(1'b1, 1'b0, 1, 0, 10);
        passo(1'b1, 1'b1, 1, 0, 10);
        passo(1'b0, 1'b1, 1, 0, 10);
        passo(1'b0, 1'b0, 1, 0, 10);
        drenar("rev_drain");
        verificar("rev_erro", erro, 1'b0);

        // Glitch of 3 cycles is rejected, 4 cycles accepted
        passo(1'b1, 1'b0, 0, 0, 3);
        passo(1'b0, 1'b0, 0, 0, 12);
        verificar("glitch_filt_a", dut.filt[1], 1'b0);
        passo(1'b1, 1'b0, 1, 0, 4);
        passo(1'b0, 1'b0, 1, 1, 12);
        drenar("glitch_drain");

        // Illegal 00->11 sets sticky erro; limpar_erro clears it
        passo(1'b1, 1'b1, 0, 0, 6);
        verificar("ilegal_erro_before", erro, 1'b0);
        esperar(1);
        verificar("ilegal_erro_set", erro, 1'b1);
        esperar(10);
        verificar("ilegal_erro_held", erro, 1'b1);
        limpar_erro = 1'b1;
        esperar(1);
        limpar_erro = 1'b0;
        verificar("ilegal_erro_cleared", erro, 1'b0);
        esperar(3);
        verificar("ilegal_erro_stays_clear", erro, 1'b0);
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("ilegal_drain");

        // Set wins over simultaneous clear
        limpar_erro = 1'b1;
        passo(1'b1, 1'b1, 0, 0, 6);
        verificar("prio_erro_before", erro, 1'b0);
        esperar(1);
        verificar("prio_erro_set", erro, 1'b1);
        esperar(1);
        verificar("prio_erro_cleared", erro, 1'b0);
        limpar_erro = 1'b0;
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("prio_drain");

        // habilitar=0 suppresses pulses and erro; no retroactive pulse
        habilitar = 1'b0;
        passo(1'b0, 1'b1, 0, 0, 10);
        habilitar = 1'b1;
        esperar(3);
        passo(1'b1, 1'b1, 1, 1, 10);
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("hab_drain");
        habilitar = 1'b0;
        passo(1'b1, 1'b1, 0, 0, 10);
        verificar("hab_erro_suppressed", erro, 1'b0);
        habilitar = 1'b1;
        esperar(3);
        verificar("hab_erro_not_retro", erro, 1'b0);
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("hab_erro_drain");

        // Hold 11 through reset and settling
        canal_a = 1'b1; canal_b = 1'b1;
        rst = 1'b1;
        esperar(3);
        rst = 1'b0;
        esperar(20);
        verificar("hold11_erro", erro, 1'b0);
        passo(1'b1, 1'b0, 1, 1, 10);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("hold11_drain");

        // Reset mid-filter clears erro and returns to INICIAL
        passo(1'b1, 1'b1, 0, 0, 10);
        verificar("midrst_erro_pre", erro, 1'b1);
        passo(1'b1, 1'b0, 0, 0, 4);
        rst = 1'b1;
        esperar(1);
        verificar("midrst_acrescer", acrescer, 1'b0);
        verificar("midrst_decrescer", decrescer, 1'b0);
        verificar("midrst_erro", erro, 1'b0);
        verificar("midrst_estado", dut.estado, 1'b0);
        rst = 1'b0;
        esperar(20);
        passo(1'b0, 1'b0, 1, 1, 10);
        drenar("midrst_drain");

        // Reset on the pulse edge drops the pulse
        passo(1'b0, 1'b1, 0, 0, LAT - 1);
        rst = 1'b1;
        esperar(1);
        verificar("pulsedrop_acrescer", acrescer, 1'b0);
        rst = 1'b0;
        esperar(20);
        passo(1'b0, 1'b0, 1, 0, 10);
        drenar("pulsedrop_drain");

        esperar(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
